// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper, frame data width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  function automatic int uart_cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous pin; 2-cycle latency, resets to 1 (idle-high line).
// No backpressure: the output follows the pin continuously.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority vote; rx_valid rises 2 + 9*CPB + H + 2 clocks after the start edge.
// A byte completing while the holding register is still full is dropped and flagged on rx_overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       fpga_sysclk,
  input  logic       rst_sys,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CPB = uart_cpb(CLK_HZ, BAUD);
  localparam int H   = CPB / 2;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] C_SAMP_LO  = CW'(H - 1);
  localparam logic [CW-1:0] C_SAMP_MID = CW'(H);
  localparam logic [CW-1:0] C_VOTE     = CW'(H + 1);
  localparam logic [CW-1:0] C_END      = CW'(CPB - 1);
  localparam logic [BW-1:0] B_LAST     = BW'(UART_DATA_BITS - 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic                      rxs;
  uart_rx_state_t            state, state_nxt;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bitn;
  logic [UART_DATA_BITS-1:0] sh;
  logic                      samp_lo, samp_mid;
  logic                      vote, at_vote, at_end;
  logic                      deliver_stb, ferr_stb;

  uart_rx_sync u_sync (
    .clk      (fpga_sysclk),
    .rst      (rst_sys),
    .async_in (uart_rxd),
    .sync_out (rxs)
  );

  assign vote    = (samp_lo & samp_mid) | (samp_lo & rxs) | (samp_mid & rxs);
  assign at_vote = (cnt == C_VOTE);
  assign at_end  = (cnt == C_END);
  assign rx_busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    deliver_stb = 1'b0;
    ferr_stb    = 1'b0;
    case (state)
      IDLE:  if (!rxs) state_nxt = START;
      START: begin
        // A start bit that votes high was a glitch; give up before the data bits.
        if (at_vote && vote) state_nxt = IDLE;
        else if (at_end)     state_nxt = DATA;
      end
      DATA:  if (at_end && bitn == B_LAST) state_nxt = STOP;
      STOP: begin
        if (at_vote) begin
          if (vote) begin
            state_nxt   = IDLE;
            deliver_stb = 1'b1;
          end else begin
            state_nxt = BREAK;
            ferr_stb  = 1'b1;
          end
        end
      end
      BREAK: if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fpga_sysclk) begin
    if (rst_sys) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge fpga_sysclk) begin
    if (rst_sys) begin
      cnt          <= '0;
      bitn         <= '0;
      sh           <= '0;
      samp_lo      <= 1'b0;
      samp_mid     <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (state == IDLE || state == BREAK || state_nxt != state || at_end) cnt <= '0;
      else                                                                 cnt <= cnt + CW'(1);

      if (state == IDLE || (state == START && at_end)) bitn <= '0;
      else if (state == DATA && at_end)                bitn <= bitn + BW'(1);

      if (cnt == C_SAMP_LO)  samp_lo  <= rxs;
      if (cnt == C_SAMP_MID) samp_mid <= rxs;
      if (state == DATA && at_vote) sh <= {vote, sh[UART_DATA_BITS-1:1]};

      rx_frame_err <= ferr_stb;
      rx_overrun   <= 1'b0;
      // Loading a fresh byte takes priority over clearing rx_valid on a handshake.
      if (deliver_stb && (!rx_valid || rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else begin
        if (deliver_stb)           rx_overrun <= 1'b1;
        if (rx_valid && rx_ready)  rx_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed checks of uart_rx against a byte-level model of 8N1 reception.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ = 16000000;
  localparam int BAUD   = 1000000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int H      = CPB / 2;
  localparam int LAT    = 2 + 9 * CPB + H + 2;

  logic       fpga_sysclk = 1'b0;
  logic       rst_sys     = 1'b1;
  logic       uart_rxd    = 1'b1;
  logic       rx_ready    = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .fpga_sysclk  (fpga_sysclk),
    .rst_sys      (rst_sys),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 fpga_sysclk = ~fpga_sysclk;

  int cyc = 0;
  always @(posedge fpga_sysclk) cyc <= cyc + 1;

  // Observed traffic, sampled mid-cycle.
  logic [7:0] got_q[$];
  int n_ferr = 0, n_ovr = 0, n_vhigh = 0, n_busy = 0, rise_cyc = -1;
  logic prev_valid = 1'b0;

  always @(negedge fpga_sysclk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_frame_err) n_ferr++;
    if (rx_overrun) n_ovr++;
    if (rx_valid) n_vhigh++;
    if (rx_busy) n_busy++;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_got();
    if (got_q.size() == 0) return 32'hDEAD_BEEF;
    return {24'h0, got_q.pop_front()};
  endfunction

  task automatic tick();
    @(posedge fpga_sysclk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) tick();
  endtask

  // One 8N1 frame, one pin value per clock. spike_off inverts one clock of every
  // data bit; abort_at pulses rst_sys on that clock and then releases the line high.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int spike_off,
                            input int abort_at, output int start_cyc);
    logic [9:0] bits;
    logic       b;
    bits      = {stop_bit, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10 * CPB; i++) begin
      b = bits[i / CPB];
      if (i / CPB >= 1 && i / CPB <= 8 && (i % CPB) == spike_off) b = ~b;
      if (i == abort_at) rst_sys = 1'b1;
      uart_rxd = b;
      tick();
      rst_sys = 1'b0;
      if (abort_at >= 0 && i >= abort_at) begin
        uart_rxd = 1'b1;
        break;
      end
    end
  endtask

  logic [7:0] exp_q[$];

  initial begin
    int sc, ferr0, ovr0, nfr;
    logic [7:0] d;

    rst_sys = 1'b1;
    repeat (3) tick();
    chk("reset_data", rx_data, 0);
    chk("reset_flags", {rx_valid, rx_busy, rx_frame_err, rx_overrun}, 0);
    rst_sys = 1'b0;

    // Single byte, consumer always ready: exact latency and a one-cycle valid.
    rx_ready = 1'b1;
    idle(5);
    rise_cyc = -1;
    n_vhigh  = 0;
    send_frame(8'hA5, 1'b1, -1, -1, sc);
    idle(4);
    chk("a5_latency", rise_cyc - sc - 1, LAT);
    chk("a5_valid_cycles", n_vhigh, 1);
    chk("a5_count", got_q.size(), 1);
    chk("a5_data", pop_got(), 8'hA5);
    chk("a5_no_errors", n_ferr + n_ovr, 0);

    // Two frames back to back with no consumer: second byte overruns.
    rx_ready = 1'b0;
    ovr0 = n_ovr;
    idle(5);
    send_frame(8'h00, 1'b1, -1, -1, sc);
    send_frame(8'hFF, 1'b1, -1, -1, sc);
    idle(4);
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_data_held", rx_data, 8'h00);
    chk("ovr_pulses", n_ovr - ovr0, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    chk("ovr_valid_cleared", rx_valid, 0);
    chk("ovr_consumed", pop_got(), 8'h00);
    chk("ovr_nothing_else", got_q.size(), 0);

    // Short low glitch on an idle line is rejected at the start-bit vote.
    rx_ready = 1'b1;
    ferr0  = n_ferr;
    n_busy = 0;
    uart_rxd = 1'b0;
    repeat (3) tick();
    idle(3 * CPB);
    chk("glitch_busy_cycles", n_busy, H + 2);
    chk("glitch_no_byte", got_q.size(), 0);
    chk("glitch_no_ferr", n_ferr - ferr0, 0);

    // Low stop bit followed by a held-low line: one framing error, then recovery.
    ferr0 = n_ferr;
    send_frame(8'h3C, 1'b0, -1, -1, sc);
    uart_rxd = 1'b0;
    repeat (40 * CPB) tick();
    chk("break_busy", rx_busy, 1);
    chk("break_ferr_once", n_ferr - ferr0, 1);
    chk("break_no_byte", got_q.size(), 0);
    idle(2 * CPB);
    chk("break_released", rx_busy, 0);
    send_frame(8'h5A, 1'b1, -1, -1, sc);
    idle(4);
    chk("after_break_data", pop_got(), 8'h5A);

    // Inverted spike on the middle vote sample of every data bit.
    send_frame(8'h96, 1'b1, H + 1, -1, sc);
    idle(4);
    chk("spike_data", pop_got(), 8'h96);

    // Reset in the middle of the data bits: nothing partial escapes.
    ferr0 = n_ferr;
    ovr0  = n_ovr;
    send_frame(8'h77, 1'b1, -1, 4 * CPB + 3, sc);
    chk("midreset_data", rx_data, 0);
    chk("midreset_flags", {rx_valid, rx_busy, rx_frame_err, rx_overrun}, 0);
    idle(3 * CPB);
    chk("midreset_no_byte", got_q.size(), 0);
    send_frame(8'h12, 1'b1, -1, -1, sc);
    idle(4);
    chk("midreset_next_data", pop_got(), 8'h12);

    // Random bytes, random single-clock spikes, random inter-frame gaps.
    nfr = 20;
    for (int k = 0; k < nfr; k++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, CPB - 2)) : -1, -1, sc);
      idle($urandom_range(0, 2 * CPB));
    end
    idle(4);
    chk("rand_count", got_q.size(), nfr);
    for (int k = 0; k < nfr; k++) chk($sformatf("rand_byte%0d", k), pop_got(), exp_q.pop_front());
    chk("rand_no_errors", (n_ferr - ferr0) + (n_ovr - ovr0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
